acc_cpu_mc: RTL and testbench

- Parametrised multicycle accumulator processor: next generation of the single-cycle top-level core.
- Adds generic data/address widths, an explicit FETCH/DECODE/EXEC state machine and a synchronous-read data RAM.
- Adds carry and zero flags with conditional branches, a HALT state, a retired-instruction counter, and a program-load port for benches and the board wrapper.
- Instruction word: opcode in bits [DATA_W-1 -: 4], operand in bits [ADDR_W-1:0].

---
 rtl/acc_cpu_pkg.sv | 34 +++
 rtl/sp_ram.sv | 37 +++
 rtl/acc_cpu_mc.sv | 180 ++++++++++++++++++
 tb/tb_acc_cpu_mc.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the multicycle accumulator core:
// opcodes, FSM state encoding and a parameter sanity check.
package acc_cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JNZ = 4'hB;
    localparam logic [3:0] OP_JC  = 4'hC;
    localparam logic [3:0] OP_LDI = 4'hD;
    localparam logic [3:0] OP_SHL = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_e;

    // The opcode field sits above the operand field, so both must fit.
    function automatic bit width_ok(input int dw, input int aw);
        return dw >= aw + 4;
    endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-write-port RAM with separate read address;
// read is combinational or registered depending on SYNC_RD.
module sp_ram #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 5,
    parameter bit SYNC_RD = 1'b0
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    generate
        if (SYNC_RD) begin : g_sync
            logic [DATA_W-1:0] rd_q;
            // Read-before-write on a same-address collision.
            always_ff @(posedge clk) begin
                rd_q <= mem_q[raddr_i];
            end
            assign rdata_o = rd_q;
        end else begin : g_async
            assign rdata_o = mem_q[raddr_i];
        end
    endgenerate

endmodule

// File: rtl/acc_cpu_mc.sv
// Multicycle accumulator CPU: FETCH/DECODE/EXEC FSM, flags,
// HALT state, retired-instruction counter and RAM load port.
module acc_cpu_mc
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic              prog_sel,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] ir_out,
    output logic [DATA_W-1:0] acc_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] dm_out,
    output logic [1:0]        state_out,
    output logic              zf,
    output logic              cf,
    output logic              halted,
    output logic [CNT_W-1:0]  instret
);

    generate
        if (!width_ok(DATA_W, ADDR_W)) begin : g_bad_w
            $error("acc_cpu_mc: DATA_W must be >= ADDR_W+4");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              zf_q, zf_d;
    logic              cf_q, cf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [3:0]        op;
    logic [ADDR_W-1:0] opd;
    logic [DATA_W-1:0] k;
    logic [DATA_W-1:0] im_rd;
    logic [DATA_W-1:0] dm_rd;
    logic [DATA_W:0]   alu_w;
    logic              wr_acc, wr_cf, take, sta_we;

    assign op  = ir_q[DATA_W-1 -: 4];
    assign opd = ir_q[ADDR_W-1:0];
    assign k   = {{(DATA_W-ADDR_W){1'b0}}, opd};

    // Load port owns both RAMs while reset is held.
    sp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_RD(1'b0)) u_imem (
        .clk     (clk),
        .we_i    (!rst && prog_we && !prog_sel),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (pc_q),
        .rdata_o (im_rd)
    );

    sp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_RD(1'b1)) u_dmem (
        .clk     (clk),
        .we_i    (rst ? sta_we : (prog_we && prog_sel)),
        .waddr_i (rst ? opd : prog_addr),
        .wdata_i (rst ? acc_q : prog_data),
        .raddr_i (opd),
        .rdata_o (dm_rd)
    );

    always_comb begin
        alu_w = {cf_q, acc_q};
        case (op)
            OP_LDA:  alu_w = {cf_q, dm_rd};
            OP_ADD:  alu_w = {1'b0, acc_q} + {1'b0, dm_rd};
            OP_SUB:  alu_w = {1'b0, acc_q} - {1'b0, dm_rd};
            OP_AND:  alu_w = {cf_q, acc_q & dm_rd};
            OP_OR:   alu_w = {cf_q, acc_q | dm_rd};
            OP_XOR:  alu_w = {cf_q, acc_q ^ dm_rd};
            OP_NOT:  alu_w = {cf_q, ~acc_q};
            OP_LDI:  alu_w = {cf_q, k};
            OP_SHL:  alu_w = {acc_q, 1'b0};
            default: alu_w = {cf_q, acc_q};
        endcase
    end

    always_comb begin
        wr_acc = op inside {OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR,
                            OP_XOR, OP_NOT, OP_LDI, OP_SHL};
        wr_cf  = op inside {OP_ADD, OP_SUB, OP_SHL};
        unique case (1'b1)
            (op == OP_JMP): take = 1'b1;
            (op == OP_JZ):  take = zf_q;
            (op == OP_JNZ): take = !zf_q;
            (op == OP_JC):  take = cf_q;
            default:        take = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = (op == OP_HLT) ? S_HALT : S_FETCH;
            default:  state_d = S_HALT;
        endcase
    end

    always_comb begin
        pc_d   = pc_q;
        ir_d   = ir_q;
        acc_d  = acc_q;
        zf_d   = zf_q;
        cf_d   = cf_q;
        cnt_d  = cnt_q;
        sta_we = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_d = im_rd;
                pc_d = pc_q + 1'b1;
            end
            S_EXEC: begin
                cnt_d  = cnt_q + 1'b1;
                sta_we = (op == OP_STA);
                if (wr_acc) begin
                    acc_d = alu_w[DATA_W-1:0];
                    zf_d  = (alu_w[DATA_W-1:0] == '0);
                end
                if (wr_cf) begin
                    cf_d = alu_w[DATA_W];
                end
                if (take) begin
                    pc_d = opd;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q  <= '0;
            ir_q  <= '0;
            acc_q <= '0;
            zf_q  <= 1'b0;
            cf_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            acc_q <= acc_d;
            zf_q  <= zf_d;
            cf_q  <= cf_d;
            cnt_q <= cnt_d;
        end
    end

    assign pc_out    = pc_q;
    assign ir_out    = ir_q;
    assign acc_out   = acc_q;
    assign alu_out   = alu_w[DATA_W-1:0];
    assign dm_out    = dm_rd;
    assign state_out = state_q;
    assign zf        = zf_q;
    assign cf        = cf_q;
    assign halted    = (state_q == S_HALT);
    assign instret   = cnt_q;

endmodule

// File: tb/tb_acc_cpu_mc.sv
// Bench for acc_cpu_mc: directed programs plus random programs,
// checked per cycle against an instruction-level reference model.
module tb_acc_cpu_mc;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int CW    = 16;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          prog_we = 1'b0;
    logic          prog_sel = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [DW-1:0] prog_data = '0;
    logic [AW-1:0] pc_out;
    logic [DW-1:0] ir_out, acc_out, alu_out, dm_out;
    logic [1:0]    state_out;
    logic          zf, cf, halted;
    logic [CW-1:0] instret;

    acc_cpu_mc #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_sel  (prog_sel),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .pc_out    (pc_out),
        .ir_out    (ir_out),
        .acc_out   (acc_out),
        .alu_out   (alu_out),
        .dm_out    (dm_out),
        .state_out (state_out),
        .zf        (zf),
        .cf        (cf),
        .halted    (halted),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] tb_imem [DEPTH];
    logic [DW-1:0] m_dmem  [DEPTH];
    int m_acc, m_pc, m_zf, m_cf, m_cnt, m_halt;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] ins(input int op, input int k);
        return DW'(op * 4096 + k);
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < DEPTH; i++) begin
            tb_imem[i] = '0;
            m_dmem[i]  = '0;
        end
    endtask

    task automatic load(input bit with_dm);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            prog_we = 1'b1; prog_sel = 1'b0;
            prog_addr = AW'(i); prog_data = tb_imem[i];
            tick();
            if (with_dm) begin
                prog_sel = 1'b1; prog_data = m_dmem[i];
                tick();
            end
        end
        prog_we = 1'b0;
        tick();
        m_acc = 0; m_pc = 0; m_zf = 0; m_cf = 0; m_cnt = 0; m_halt = 0;
        chk("rst_pc", pc_out, 0);
        chk("rst_acc", acc_out, 0);
        chk("rst_ir", ir_out, 0);
        chk("rst_state", state_out, 0);
        chk("rst_halted", halted, 0);
        chk("rst_zf", zf, 0);
        chk("rst_cf", cf, 0);
        chk("rst_instret", instret, 0);
        rst = 1'b1;
    endtask

    task automatic model_step();
        int op, k, mv, sum;
        op = int'(tb_imem[m_pc]) / 4096;
        k  = int'(tb_imem[m_pc]) % 32;
        mv = int'(m_dmem[k]);
        m_pc = (m_pc + 1) % DEPTH;
        case (op)
            1: m_acc = mv;
            2: m_dmem[k] = DW'(m_acc);
            3: begin sum = m_acc + mv; m_cf = int'(sum > 65535); m_acc = sum % 65536; end
            4: begin m_cf = int'(m_acc < mv); m_acc = (m_acc - mv + 65536) % 65536; end
            5: m_acc = m_acc & mv;
            6: m_acc = m_acc | mv;
            7: m_acc = m_acc ^ mv;
            8: m_acc = 65535 - m_acc;
            9: m_pc = k;
            10: if (m_zf != 0) m_pc = k;
            11: if (m_zf == 0) m_pc = k;
            12: if (m_cf != 0) m_pc = k;
            13: m_acc = k;
            14: begin m_cf = m_acc / 32768; m_acc = (m_acc * 2) % 65536; end
            15: m_halt = 1;
            default: ;
        endcase
        if (op == 1 || (op >= 3 && op <= 8) || op == 13 || op == 14)
            m_zf = int'(m_acc == 0);
        m_cnt = (m_cnt + 1) % 65536;
    endtask

    task automatic do_instr();
        int k;
        k = int'(tb_imem[m_pc]) % 32;
        tick();
        chk("state_decode", state_out, 1);
        chk("ir", ir_out, tb_imem[m_pc]);
        chk("pc_fetch", pc_out, (m_pc + 1) % DEPTH);
        tick();
        chk("state_exec", state_out, 2);
        chk("dm_out", dm_out, m_dmem[k]);
        model_step();
        tick();
        chk("state_next", state_out, (m_halt != 0) ? 3 : 0);
        chk("acc", acc_out, m_acc);
        chk("pc", pc_out, m_pc);
        chk("zf", zf, m_zf);
        chk("cf", cf, m_cf);
        chk("instret", instret, m_cnt);
        chk("halted", halted, m_halt);
    endtask

    task automatic run(input int max_steps);
        for (int s = 0; s < max_steps && m_halt == 0; s++) do_instr();
        if (m_halt != 0) begin
            repeat (3) begin
                tick();
                chk("halt_state", state_out, 3);
                chk("halt_pc", pc_out, m_pc);
                chk("halt_acc", acc_out, m_acc);
                chk("halt_instret", instret, m_cnt);
            end
        end
    endtask

    initial begin
        int op;
        // Reset, LDI and HLT
        clear_mem();
        tb_imem[0] = ins(13, 5); tb_imem[1] = ins(15, 0);
        load(1'b1);
        run(10);
        chk("t1_acc", acc_out, 5);
        chk("t1_instret", instret, 2);
        chk("t1_halted", halted, 1);
        chk("t1_pc", pc_out, 2);

        // Add with carry, taken JC
        clear_mem();
        m_dmem[1] = 16'hFFFF;
        tb_imem[0] = ins(13, 1); tb_imem[1] = ins(3, 1); tb_imem[2] = ins(12, 5);
        tb_imem[3] = ins(15, 0); tb_imem[4] = ins(15, 0);
        tb_imem[5] = ins(13, 7); tb_imem[6] = ins(15, 0);
        load(1'b1);
        run(2);
        chk("t2_add_acc", acc_out, 0);
        chk("t2_add_zf", zf, 1);
        chk("t2_add_cf", cf, 1);
        run(10);
        chk("t2_acc", acc_out, 7);
        chk("t2_instret", instret, 5);

        // Subtract with borrow, store and reload
        clear_mem();
        m_dmem[2] = 16'd9;
        tb_imem[0] = ins(13, 3); tb_imem[1] = ins(4, 2); tb_imem[2] = ins(2, 4);
        tb_imem[3] = ins(1, 4); tb_imem[4] = ins(15, 0);
        load(1'b1);
        run(10);
        chk("t3_acc", acc_out, 16'hFFFA);
        chk("t3_cf", cf, 1);
        chk("t3_zf", zf, 0);
        chk("t3_dmem4", m_dmem[4], 16'hFFFA);

        // Countdown loop with JNZ
        clear_mem();
        m_dmem[0] = 16'd4; m_dmem[1] = 16'd1;
        tb_imem[0] = ins(1, 0); tb_imem[1] = ins(4, 1);
        tb_imem[2] = ins(11, 1); tb_imem[3] = ins(15, 0);
        load(1'b1);
        run(20);
        chk("t4_acc", acc_out, 0);
        chk("t4_zf", zf, 1);
        chk("t4_instret", instret, 10);

        // PC wraps 31->0; JC at 0 falls through first, is taken second
        clear_mem();
        m_dmem[0] = 16'h8000;
        tb_imem[0] = ins(12, 2); tb_imem[1] = ins(9, 3);
        tb_imem[2] = ins(15, 0); tb_imem[3] = ins(1, 0);
        tb_imem[31] = ins(14, 0);
        load(1'b1);
        run(40);
        chk("t5_instret", instret, 33);
        chk("t5_pc", pc_out, 3);
        chk("t5_halted", halted, 1);

        // Reset in EXEC of STA; load-port writes ignored while running
        clear_mem();
        m_dmem[5] = 16'h00AA; m_dmem[3] = 16'h0011;
        tb_imem[0] = ins(1, 5); tb_imem[1] = ins(2, 3); tb_imem[2] = ins(15, 0);
        load(1'b1);
        prog_we = 1'b1; prog_sel = 1'b1; prog_addr = 5'd3; prog_data = 16'hBEEF;
        do_instr();
        prog_we = 1'b0;
        chk("t6_acc_aa", acc_out, 16'h00AA);
        tick();
        tick();
        chk("t6_in_exec", state_out, 2);
        rst = 1'b0;
        tick();
        chk("t6_acc", acc_out, 0);
        chk("t6_state", state_out, 0);
        chk("t6_pc", pc_out, 0);
        chk("t6_instret", instret, 0);
        tick();
        chk("t6_state2", state_out, 0);
        for (int i = 0; i < DEPTH; i++) tb_imem[i] = '0;
        tb_imem[0] = ins(1, 3); tb_imem[1] = ins(15, 0);
        load(1'b0);
        run(5);
        chk("t6_dmem3", acc_out, 16'h0011);

        // Random programs
        repeat (25) begin
            for (int i = 0; i < DEPTH; i++) begin
                op = int'($urandom_range(0, 15));
                if (op == 15 && $urandom_range(0, 2) != 0) op = 0;
                tb_imem[i] = DW'(op * 4096 + int'($urandom_range(0, 4095)));
                case ($urandom_range(0, 5))
                    0: m_dmem[i] = '0;
                    1: m_dmem[i] = 16'hFFFF;
                    2: m_dmem[i] = 16'h8000;
                    default: m_dmem[i] = DW'($urandom);
                endcase
            end
            load(1'b1);
            run(40);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
